// File: rtl/run_sequencer_pkg.sv
// Shared state encoding, error codes and default widths for the run sequencer.
// Pure declarations: no latency, no flow control.
package osg_seq_pkg;
    localparam int GAP_W_DEF = 17;
    localparam int REP_W_DEF = 8;
    localparam int TMO_W_DEF = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_GAP,
        S_DONE
    } seq_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_NOCFG   = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;
endpackage

// File: rtl/run_sequencer_if.sv
// Control/status bundle between the run controller (master) and the sequencer (slave).
// Wires only: no latency; no backpressure, every signal is a level or a one-cycle pulse.
interface run_sequencer_if
    import osg_seq_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF,
    parameter int REP_W = REP_W_DEF,
    parameter int TMO_W = TMO_W_DEF
);
    logic             start_req;
    logic             abort;
    logic             cfg_valid;
    logic [REP_W-1:0] rep_cnt;
    logic [GAP_W-1:0] gap;
    logic [TMO_W-1:0] tmo;
    logic             end_flg;
    logic             chain_start;
    logic             busy;
    logic             done;
    logic             err;
    logic [1:0]       err_code;
    logic [REP_W-1:0] burst_idx;

    modport master (
        output start_req, abort, cfg_valid, rep_cnt, gap, tmo, end_flg,
        input  chain_start, busy, done, err, err_code, burst_idx
    );

    modport slave (
        input  start_req, abort, cfg_valid, rep_cnt, gap, tmo, end_flg,
        output chain_start, busy, done, err, err_code, burst_idx
    );
endinterface

// File: rtl/run_sequencer_counter.sv
// Loadable, clearable, saturating up/down counter with a terminal-count compare.
// Latency: count updates one clk after clr/load/en; no backpressure.
module seq_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         en,
    input  logic         up,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en) begin
            if (up && cnt != '1) begin
                cnt <= cnt + W'(1);
            end else if (!up && cnt != '0) begin
                cnt <= cnt - W'(1);
            end
        end
    end

    assign tc = (cnt == term);
endmodule

// File: rtl/run_sequencer.sv
// Burst run controller for the pulse/delay chain; start_req -> chain_start in 1 clk, all outputs registered.
// No backpressure: one-cycle pulses in and out. CONT_MODE_EN enables continuous mode on rep_cnt=0.
module run_sequencer
    import osg_seq_pkg::*;
#(
    parameter int GAP_W = GAP_W_DEF,
    parameter int REP_W = REP_W_DEF,
    parameter int TMO_W = TMO_W_DEF
) (
    input logic            clk,
    input logic            rst,
    run_sequencer_if.slave io
);
    seq_state_t       state, state_nxt;
    logic [REP_W-1:0] rep_sh;
    logic [GAP_W-1:0] gap_sh;
    logic [TMO_W-1:0] tmo_sh;
    logic             chain_start_r, busy_r, done_r, err_r;
    logic [1:0]       err_code_r;
    logic [REP_W-1:0] burst_idx_r, idx_sat, idx_plus;
    logic             accept, nocfg, aborting, last_burst, wd_tc, gap_tc, wd_exp;
    logic             wd_clr, gap_load, idx_bump, set_timeout;

    assign accept   = (state == S_IDLE) && io.start_req && io.cfg_valid;
    assign nocfg    = (state == S_IDLE) && io.start_req && !io.cfg_valid;
    assign aborting = (state != S_IDLE) && io.abort;
    assign wd_exp   = (tmo_sh != '0) && wd_tc;
    assign idx_sat  = (burst_idx_r == '1) ? burst_idx_r : burst_idx_r + REP_W'(1);

`ifdef CONT_MODE_EN
    logic cont_sh;
    assign idx_plus   = cont_sh ? burst_idx_r + REP_W'(1) : idx_sat;
    assign last_burst = !cont_sh && (idx_plus == rep_sh);
`else
    assign idx_plus   = idx_sat;
    assign last_burst = (idx_plus == rep_sh);
`endif

    // Watchdog counts RUN cycles from 0; it fires on the edge it would reach tmo.
    seq_counter #(.W(TMO_W)) u_wdog (
        .clk(clk), .rst(rst), .clr(wd_clr), .load(1'b0), .en(state == S_RUN), .up(1'b1),
        .load_val('0), .term(tmo_sh - TMO_W'(1)), .tc(wd_tc)
    );

    // Gap counter is loaded with gap and runs down to 0, so GAP lasts gap+1 cycles.
    seq_counter #(.W(GAP_W)) u_gap (
        .clk(clk), .rst(rst), .clr(1'b0), .load(gap_load), .en(state == S_GAP), .up(1'b0),
        .load_val(gap_sh), .term('0), .tc(gap_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        wd_clr      = 1'b0;
        gap_load    = 1'b0;
        idx_bump    = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_LAUNCH;
            S_LAUNCH: begin
                wd_clr    = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (io.end_flg) begin
                    idx_bump = 1'b1;
                    if (last_burst) begin
                        state_nxt = S_DONE;
                    end else if (gap_sh == '0) begin
                        state_nxt = S_LAUNCH;
                    end else begin
                        gap_load  = 1'b1;
                        state_nxt = S_GAP;
                    end
                end else if (wd_exp) begin
                    set_timeout = 1'b1;
                    state_nxt   = S_IDLE;
                end
            end
            S_GAP:    if (gap_tc) state_nxt = S_LAUNCH;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (aborting) begin
            state_nxt   = S_IDLE;
            gap_load    = 1'b0;
            idx_bump    = 1'b0;
            set_timeout = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chain_start_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            err_r         <= 1'b0;
            err_code_r    <= ERR_NONE;
            burst_idx_r   <= '0;
            rep_sh        <= '0;
            gap_sh        <= '0;
            tmo_sh        <= '0;
`ifdef CONT_MODE_EN
            cont_sh       <= 1'b0;
`endif
        end else begin
            chain_start_r <= (state_nxt == S_LAUNCH);
            busy_r        <= (state_nxt != S_IDLE);
            done_r        <= (state_nxt == S_DONE);
            if (accept) begin
`ifdef CONT_MODE_EN
                rep_sh  <= io.rep_cnt;
                cont_sh <= (io.rep_cnt == '0);
`else
                rep_sh  <= (io.rep_cnt == '0) ? REP_W'(1) : io.rep_cnt;
`endif
                gap_sh      <= io.gap;
                tmo_sh      <= io.tmo;
                burst_idx_r <= '0;
                err_r       <= 1'b0;
                err_code_r  <= ERR_NONE;
            end else if (nocfg) begin
                err_r      <= 1'b1;
                err_code_r <= ERR_NOCFG;
            end else if (aborting) begin
`ifdef CONT_MODE_EN
                if (!cont_sh) err_r <= 1'b1;
`else
                err_r <= 1'b1;
`endif
                err_code_r <= ERR_ABORT;
            end else if (set_timeout) begin
                err_r      <= 1'b1;
                err_code_r <= ERR_TIMEOUT;
            end
            if (idx_bump) burst_idx_r <= idx_plus;
        end
    end

    assign io.chain_start = chain_start_r;
    assign io.busy        = busy_r;
    assign io.done        = done_r;
    assign io.err         = err_r;
    assign io.err_code    = err_code_r;
    assign io.burst_idx   = burst_idx_r;
endmodule

// File: tb/tb_run_sequencer.sv
// Directed scoreboard bench for run_sequencer: expected launch/done/idle events are queued at stimulus time
// and a negedge monitor pops and compares them as the DUT produces them.
module tb_run_sequencer;
    localparam int K_LAUNCH = 0;
    localparam int K_DONE   = 1;
    localparam int K_IDLE   = 2;

    typedef struct {
        int         kind;
        int         t;
        logic       err;
        logic [1:0] code;
        logic [7:0] idx;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    logic prev_busy = 1'b0;
    ev_t  q[$];

    run_sequencer_if #(.GAP_W(17), .REP_W(8), .TMO_W(24)) io ();

    run_sequencer #(.GAP_W(17), .REP_W(8), .TMO_W(24)) dut (
        .clk(clk),
        .rst(rst),
        .io (io.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push(input int kind, input int t, input logic err, input logic [1:0] code,
                        input logic [7:0] idx);
        ev_t e;
        e.kind = kind; e.t = t; e.err = err; e.code = code; e.idx = idx;
        q.push_back(e);
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_end(input int t);
        at(t);
        io.end_flg = 1'b1;
        at(t + 1);
        io.end_flg = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_chain_start"}, int'(io.chain_start), 0);
        chk({tag, "_busy"},        int'(io.busy), 0);
        chk({tag, "_done"},        int'(io.done), 0);
        chk({tag, "_err"},         int'(io.err), 0);
        chk({tag, "_err_code"},    int'(io.err_code), 0);
        chk({tag, "_burst_idx"},   int'(io.burst_idx), 0);
    endtask

    task automatic mon_event(input int kind);
        ev_t e;
        if (q.size() == 0) begin
            n_chk++;
            $display("FAIL sb_unexpected: got event kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_cycle", cyc, e.t);
            if (kind == K_IDLE) begin
                chk("sb_err",       int'(io.err), int'(e.err));
                chk("sb_err_code",  int'(io.err_code), int'(e.code));
                chk("sb_burst_idx", int'(io.burst_idx), int'(e.idx));
            end
        end
    endtask

    always @(negedge clk) begin
        if (io.chain_start === 1'b1) mon_event(K_LAUNCH);
        if (io.done === 1'b1) mon_event(K_DONE);
        if (prev_busy === 1'b1 && io.busy === 1'b0) mon_event(K_IDLE);
        prev_busy = io.busy;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation still running at cycle %0d, expected completion", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        io.start_req = 1'b0;
        io.abort     = 1'b0;
        io.cfg_valid = 1'b1;
        io.rep_cnt   = '0;
        io.gap       = '0;
        io.tmo       = '0;
        io.end_flg   = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;
        at(cyc + 2);

        // Three bursts, gap 5; stray start/end pulses and mid-run config changes must be ignored.
        n = cyc + 1;
        io.rep_cnt = 8'd3; io.gap = 17'd5; io.tmo = 24'd0; io.start_req = 1'b1;
        push(K_LAUNCH, n, 0, 0, 0);
        push(K_LAUNCH, n + 27, 0, 0, 0);
        push(K_LAUNCH, n + 54, 0, 0, 0);
        push(K_DONE,   n + 75, 0, 0, 0);
        push(K_IDLE,   n + 76, 1'b0, 2'b00, 8'd3);
        at(n); io.start_req = 1'b0;
        at(n + 5); io.start_req = 1'b1; io.rep_cnt = 8'd1; io.gap = 17'd0;
        at(n + 6); io.start_req = 1'b0;
        pulse_end(n + 20);
        pulse_end(n + 23);
        pulse_end(n + 27);
        pulse_end(n + 47);
        pulse_end(n + 74);
        at(n + 80);
        chk("run3_burst_idx", int'(io.burst_idx), 3);
        chk("run3_err", int'(io.err), 0);

        // Start without configuration loaded.
        n = cyc + 1;
        io.cfg_valid = 1'b0; io.start_req = 1'b1;
        at(n); io.start_req = 1'b0;
        chk("nocfg_err", int'(io.err), 1);
        chk("nocfg_err_code", int'(io.err_code), 1);
        chk("nocfg_busy", int'(io.busy), 0);
        at(n + 3);
        chk("nocfg_busy_later", int'(io.busy), 0);
        io.cfg_valid = 1'b1;

        // Watchdog timeout after 100 RUN cycles; accepted start clears the old error.
        n = cyc + 1;
        io.rep_cnt = 8'd1; io.gap = 17'd0; io.tmo = 24'd100; io.start_req = 1'b1;
        push(K_LAUNCH, n, 0, 0, 0);
        push(K_IDLE,   n + 101, 1'b1, 2'b10, 8'd0);
        at(n); io.start_req = 1'b0;
        chk("start_clears_err", int'(io.err), 0);
        chk("start_clears_code", int'(io.err_code), 0);
        at(n + 110);

        // Abort coincident with the second end_flg.
        n = cyc + 1;
        io.rep_cnt = 8'd4; io.gap = 17'd5; io.tmo = 24'd0; io.start_req = 1'b1;
        push(K_LAUNCH, n, 0, 0, 0);
        push(K_LAUNCH, n + 27, 0, 0, 0);
        push(K_IDLE,   n + 48, 1'b1, 2'b11, 8'd1);
        at(n); io.start_req = 1'b0;
        pulse_end(n + 20);
        at(n + 47); io.end_flg = 1'b1; io.abort = 1'b1;
        at(n + 48); io.end_flg = 1'b0; io.abort = 1'b0;
        at(n + 70);

        // Reset during GAP, then a single burst with rep_cnt=0 and gap=0.
        n = cyc + 1;
        io.rep_cnt = 8'd2; io.gap = 17'd5; io.start_req = 1'b1;
        push(K_LAUNCH, n, 0, 0, 0);
        push(K_IDLE,   n + 24, 1'b0, 2'b00, 8'd0);
        at(n); io.start_req = 1'b0;
        pulse_end(n + 20);
        at(n + 23); rst = 1'b1;
        at(n + 24);
        check_outputs_zero("midrun_rst");
        rst = 1'b0;
        io.rep_cnt = 8'd0; io.gap = 17'd0; io.start_req = 1'b1;
        n = n + 25;
        push(K_LAUNCH, n, 0, 0, 0);
        push(K_DONE,   n + 21, 0, 0, 0);
        push(K_IDLE,   n + 22, 1'b0, 2'b00, 8'd1);
        at(n); io.start_req = 1'b0;
        pulse_end(n + 20);
        at(n + 30);

`ifdef CONT_MODE_EN
        // Continuous mode: relaunch end_flg+4 cycles later until abort; abort sets code but not err.
        n = cyc + 1;
        io.rep_cnt = 8'd0; io.gap = 17'd2; io.tmo = 24'd0; io.start_req = 1'b1;
        push(K_LAUNCH, n, 0, 0, 0);
        push(K_LAUNCH, n + 9, 0, 0, 0);
        push(K_LAUNCH, n + 18, 0, 0, 0);
        push(K_IDLE,   n + 26, 1'b0, 2'b11, 8'd3);
        at(n); io.start_req = 1'b0;
        pulse_end(n + 5);
        pulse_end(n + 14);
        pulse_end(n + 23);
        at(n + 25); io.abort = 1'b1;
        at(n + 26); io.abort = 1'b0;
        at(n + 35);
`endif

        at(cyc + 5);
        chk("sb_drain", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
- Run controller that sequences the 16-channel Pulse/Delay chain.
- Accepts a start request from the Start block or PC command once channel configuration is loaded.
- Emits a one-cycle launch strobe to the chain and waits for the chain end flag.
- Repeats the burst a programmed number of times with a programmed idle gap, under a watchdog, and reports busy/done/error status.

Parameters:
- GAP_W, 17, width of inter-burst gap count (matches the 17-bit channel duration fields)
- REP_W, 8, width of burst repeat count and burst index
- TMO_W, 24, width of watchdog timeout count

Ports:
- clk  in  1  system clock (PLL output)
- rst  in  1  synchronous reset, active-high
- start_req  in  1  single-cycle start request
- abort  in  1  single-cycle abort request
- cfg_valid  in  1  high when channel configuration RAM is loaded
- rep_cnt  in  REP_W  number of bursts per run; 0 treated as 1
- gap  in  GAP_W  idle clk cycles between bursts
- tmo  in  TMO_W  watchdog limit in clk cycles per burst; 0 disables the watchdog
- end_flg  in  1  single-cycle chain-complete pulse (from the delay-stretch block)
- chain_start  out  1  one-cycle launch strobe to all PL_start inputs
- busy  out  1  high from LAUNCH entry until return to IDLE
- done  out  1  one-cycle pulse on successful completion of all bursts
- err  out  1  sticky error flag; cleared on the next accepted start
- err_code  out  2  00 none, 01 NOCFG, 10 TIMEOUT, 11 ABORT
- burst_idx  out  REP_W  count of bursts completed in the current run

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE, every output 0, internal counters 0.
- All outputs are registered.
- States: IDLE, LAUNCH, RUN, GAP, DONE.
- IDLE:
  - start_req & cfg_valid: latch rep_cnt (0→1), gap and tmo into shadow registers; clear burst_idx, err and err_code; go to LAUNCH.
  - start_req & !cfg_valid: err=1, err_code=01; stay in IDLE.
- LAUNCH: chain_start=1 for exactly one cycle; clear watchdog; go to RUN. Latency is start_req at edge N → chain_start high during cycle N+1.
- RUN: watchdog increments each cycle.
  - end_flg: burst_idx+1. If the new burst_idx equals the shadow rep count, go to DONE. Otherwise, if gap=0 go to LAUNCH; else load the gap counter and go to GAP.
  - Watchdog reaches tmo (tmo≠0): err=1, err_code=10, go to IDLE.
- GAP: count gap cycles, then go to LAUNCH. The first chain_start of the next burst follows the last end_flg by gap+2 cycles.
- DONE: done=1 for one cycle; go to IDLE; burst_idx holds its final value.
- abort in any non-IDLE state: err=1, err_code=11, go to IDLE next cycle; no further chain_start.
- Simultaneous events and stray inputs:
  - abort with end_flg: abort wins.
  - end_flg with watchdog expiry: end_flg wins.
  - start_req while busy: ignored.
  - end_flg in IDLE, GAP or LAUNCH: ignored.
  - rep_cnt/gap/tmo changes mid-run: no effect (shadowed).
  - rst mid-run: immediate return to IDLE with all outputs 0; no done pulse.
- Widths: all counters are unsigned, exact width, no wrap. burst_idx saturates at 2^REP_W−1.

Optional Feature:
- Macro CONT_MODE_EN.
- Defined: rep_cnt=0 selects continuous mode. Bursts repeat until abort, burst_idx wraps modulo 2^REP_W, done never asserts, and abort in continuous mode sets err_code=11 but not err.
- Undefined: rep_cnt=0 is treated as 1; no continuous mode logic is synthesised.

Decomposition:
- Package osg_seq_pkg holds:
  - state encoding (IDLE, LAUNCH, RUN, GAP, DONE)
  - err_code constants ERR_NONE, ERR_NOCFG, ERR_TIMEOUT, ERR_ABORT
  - default widths
- One sub-module, seq_counter: a loadable, clearable up/down counter with a terminal-count flag, parameterised width. It is instantiated twice, for the watchdog and the gap counter.

Test Plan:
- rep_cnt=3, gap=5, tmo=0, cfg_valid=1, end_flg 20 cycles after each chain_start → 3 chain_start pulses, each pair 27 cycles apart; done once; burst_idx=3; err=0.
- cfg_valid=0, start_req pulse → no chain_start; err=1; err_code=01; busy stays 0.
- tmo=100, end_flg never driven → err=1, err_code=10, return to IDLE 101 cycles after chain_start; busy falls.
- abort in the same cycle as the 2nd end_flg, rep_cnt=4 → err_code=11; burst_idx=1; no further chain_start; no done.
- rst asserted during GAP, then start_req with rep_cnt=0, gap=0 → outputs 0 after rst; next run produces exactly 1 burst; done pulses.
- With CONT_MODE_EN, rep_cnt=0, gap=2 → chain_start repeats every end_flg+4 cycles until abort; done never asserts.
